hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage RV32 core: detects load-use hazards the forwarding path cannot cover,
//  and generates per-stage stall/flush controls for branch/jump redirects and MEM-stage traps.
//  Runs the start/busy/done handshake with the multi-cycle mul/div unit (MDU) sitting in EX.
//  Sits beside the forwarding unit; its controls drive the PC, IF_ID, ID_EX and EX_MEM registers.
// PARAMETERS
//  REG_AW       5    register/CSR-shadow index width
//  MDU_TIMEOUT  64   max cycles waiting for mdu_done before abort
//  CNT_W        32   width of performance counters (see CONFIGURATION)
// PORTS
//  clk            in   1      core clock
//  rst_n          in   1      async active-low reset
//  rs1,rs2,rs3    in   REG_AW ID-stage source indices; use_r1/2/3 in 1: source actually read
//  ID_EX_rd       in   REG_AW EX-stage destination; ID_EX_rw in 1: EX writes GPR
//  ID_EX_WBSel    in   2      EX-stage writeback select; bit0=1 means load
//  ex_redirect    in   1      EX resolved taken branch/jump (valid only when EX not stalled)
//  ex_mdu_op      in   1      EX holds a mul/div instruction
//  mem_trap       in   1      exception/interrupt taken at MEM (highest priority)
//  mdu_done       in   1      MDU result valid (single-cycle pulse)
//  mdu_start      out  1      one-cycle launch pulse to MDU
//  mdu_abort      out  1      one-cycle kill pulse to MDU
//  pc_stall, if_id_stall, id_ex_stall        out 1  hold stage register
//  if_id_flush, id_ex_flush, ex_mem_flush    out 1  insert bubble into stage register
//  mdu_timeout_err out 1      sticky: MDU timed out; cleared only by reset
// BEHAVIOUR
//  - FSM states: IDLE, MDU_BUSY, MDU_DONE. Reset: IDLE, timeout counter 0, all outputs 0.
//  - Priority per cycle: mem_trap > MDU sequencing > ex_redirect > load-use.
//  - load-use: ID_EX_WBSel[0] & ID_EX_rw & ID_EX_rd!=0 & ((use_r1&rs1==ID_EX_rd)|(use_r2&rs2==ID_EX_rd))
//    -> pc_stall=if_id_stall=1, id_ex_flush=1 for exactly that cycle (one bubble); CSR rs3 never stalls.
//  - ex_redirect (state IDLE): if_id_flush=id_ex_flush=1, no stall; suppresses load-use that cycle.
//  - IDLE & ex_mdu_op & !mem_trap: mdu_start=1 same cycle, stall PC/IF_ID/ID_EX, ex_mem_flush=1; -> MDU_BUSY.
//  - MDU_BUSY: same stalls + ex_mem_flush each cycle; counter increments.
//    mdu_done -> MDU_DONE; counter==MDU_TIMEOUT-1 without done -> set mdu_timeout_err, mdu_abort=1, -> IDLE.
//  - MDU_DONE: one cycle, no stall, no flush (EX result advances to EX_MEM); -> IDLE, counter cleared.
//    ex_mdu_op still high in MDU_DONE must NOT relaunch (same instruction leaving EX).
//  - mem_trap any state: if_id_flush=id_ex_flush=ex_mem_flush=1, no stalls; in MDU_BUSY also mdu_abort=1;
//    next state IDLE, counter cleared. mdu_done coincident with mem_trap is discarded.
//  - Stall and flush of the same register never both asserted except id_ex: flush wins there.
//  - Async reset mid-MDU: FSM to IDLE immediately; no mdu_abort pulse is issued (MDU reset shares rst_n).
//  - All stall/flush outputs are combinational from state + inputs; only FSM, counter, err are registered.
// CONFIGURATION
//  HAZARD_PERF_EN defined: adds outputs perf_ld_stall, perf_mdu_stall, perf_flush [CNT_W-1:0]:
//    count load-use bubbles, MDU_BUSY/start stall cycles, and cycles with any flush; reset 0, wrap at 2^CNT_W.
//  Undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  Shared package/header: FSM state encodings (HZ_IDLE=2'd0, HZ_BUSY=2'd1, HZ_DONE=2'd2), WBSel load-bit index.
//  One sub-module: hazard_perf_cnt (three saturating-free wrap counters) instantiated only under HAZARD_PERF_EN.
// TESTING
//  1 load x5 in EX, ID add uses rs1=x5 -> 1 cycle pc/if_id stall + id_ex_flush, then normal flow.
//  2 load x0 in EX, ID uses x0; or use_r2=0 with rs2 match -> no stall.
//  3 ex_mdu_op, mdu_done after 10 cycles -> mdu_start 1 pulse, 11 stall cycles, MDU_DONE, no relaunch.
//  4 MDU never done, MDU_TIMEOUT=8 -> abort pulse at cycle 8, err sticky until rst_n low.
//  5 mem_trap during MDU_BUSY with simultaneous mdu_done -> 3 flushes, mdu_abort, IDLE, done ignored.
//  6 ex_redirect with load-use match same cycle -> flushes only, no stall; perf_flush +1 (HAZARD_PERF_EN).

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer.
// Contents: FSM state encodings, index of the load bit inside the
// ID_EX writeback-select field.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    HZ_IDLE = 2'd0,
    HZ_BUSY = 2'd1,
    HZ_DONE = 2'd2
  } hz_state_t;

  // ID_EX_WBSel[WBSEL_LOAD_BIT] set means the EX instruction is a load
  localparam int WBSEL_LOAD_BIT = 0;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Performance counters for the hazard sequencer.
// Three free-running, wrapping counters that advance by one on each cycle
// their increment strobe is high.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   inc_ld                load-use bubble issued this cycle
//   inc_mdu               MDU launch/busy stall cycle
//   inc_flush             any flush asserted this cycle
//   perf_ld_stall, perf_mdu_stall, perf_flush  [CNT_W-1:0] counter values
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_ld,
  input  logic             inc_mdu,
  input  logic             inc_flush,
  output logic [CNT_W-1:0] perf_ld_stall,
  output logic [CNT_W-1:0] perf_mdu_stall,
  output logic [CNT_W-1:0] perf_flush
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ld_stall  <= '0;
      perf_mdu_stall <= '0;
      perf_flush     <= '0;
    end else begin
      if (inc_ld)    perf_ld_stall  <= perf_ld_stall + 1'b1;
      if (inc_mdu)   perf_mdu_stall <= perf_mdu_stall + 1'b1;
      if (inc_flush) perf_flush     <= perf_flush + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage RV32 core.
// Detects load-use hazards, generates stall/flush controls for branch/jump
// redirects and MEM-stage traps, and sequences the multi-cycle MDU in EX.
// Optional feature macro: HAZARD_PERF_EN adds three performance counters.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   rs1..rs3, use_r1..use_r3       ID source indices and read enables
//   ID_EX_rd, ID_EX_rw, ID_EX_WBSel EX destination, GPR write, writeback select
//   ex_redirect, ex_mdu_op         EX taken branch/jump, EX holds mul/div
//   mem_trap                       trap taken at MEM (highest priority)
//   mdu_done                       MDU result valid pulse
//   mdu_start, mdu_abort           MDU launch / kill pulses
//   pc_stall, if_id_stall, id_ex_stall         stage holds
//   if_id_flush, id_ex_flush, ex_mem_flush     stage bubbles
//   mdu_timeout_err                sticky MDU timeout flag
//   dbg_state                      current FSM state
//   perf_ld_stall, perf_mdu_stall, perf_flush  (HAZARD_PERF_EN only)
//
// MDU handshake: mdu_start is a one-cycle pulse issued in the same cycle the
// FSM leaves IDLE; the MDU answers with a one-cycle mdu_done pulse at any
// later cycle. While waiting, the front end and ID_EX are held and EX_MEM
// receives bubbles. mdu_abort is a one-cycle pulse that kills the MDU
// operation (trap or timeout); no done is expected after it.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  input  logic [REG_AW-1:0] rs3,
  input  logic              use_r1,
  input  logic              use_r2,
  input  logic              use_r3,
  input  logic [REG_AW-1:0] ID_EX_rd,
  input  logic              ID_EX_rw,
  input  logic [1:0]        ID_EX_WBSel,
  input  logic              ex_redirect,
  input  logic              ex_mdu_op,
  input  logic              mem_trap,
  input  logic              mdu_done,
  output logic              mdu_start,
  output logic              mdu_abort,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_ex_stall,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              mdu_timeout_err,
  output hz_state_t         dbg_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_ld_stall,
  output logic [CNT_W-1:0]  perf_mdu_stall,
  output logic [CNT_W-1:0]  perf_flush
`endif
);

  localparam int CTR_W = $clog2(MDU_TIMEOUT + 1);

  hz_state_t        state, state_n;
  logic [CTR_W-1:0] cnt, cnt_n;
  logic             err_set;
  logic             load_use;
  logic             timeout_hit;
  logic             ld_bubble;
  logic             mdu_stall_cyc;

  // CSR source rs3 never causes a stall; WBSel[1] is irrelevant here.
  logic unused_inputs;
  assign unused_inputs = ^{rs3, use_r3, ID_EX_WBSel[1]};
`ifndef HAZARD_PERF_EN
  localparam int unused_cnt_w = CNT_W;
`endif

  assign load_use = ID_EX_WBSel[WBSEL_LOAD_BIT] & ID_EX_rw & (ID_EX_rd != '0) &
                    ((use_r1 & (rs1 == ID_EX_rd)) | (use_r2 & (rs2 == ID_EX_rd)));

  assign timeout_hit = (cnt == CTR_W'(MDU_TIMEOUT - 1));
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= HZ_IDLE;
      cnt             <= '0;
      mdu_timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (err_set) mdu_timeout_err <= 1'b1;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    err_set       = 1'b0;
    mdu_start     = 1'b0;
    mdu_abort     = 1'b0;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    ld_bubble     = 1'b0;
    mdu_stall_cyc = 1'b0;

    if (mem_trap) begin
      // Trap wins over everything; a coincident mdu_done is dropped.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mdu_abort    = (state == HZ_BUSY);
      state_n      = HZ_IDLE;
      cnt_n        = '0;
    end else begin
      unique case (state)
        HZ_IDLE: begin
          if (ex_mdu_op) begin
            mdu_start     = 1'b1;
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_flush  = 1'b1;
            mdu_stall_cyc = 1'b1;
            state_n       = HZ_BUSY;
            cnt_n         = '0;
          end else if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            ld_bubble   = 1'b1;
          end
        end
        HZ_BUSY: begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_flush  = 1'b1;
          mdu_stall_cyc = 1'b1;
          if (mdu_done) begin
            state_n = HZ_DONE;
            cnt_n   = '0;
          end else if (timeout_hit) begin
            mdu_abort = 1'b1;
            err_set   = 1'b1;
            state_n   = HZ_IDLE;
            cnt_n     = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        HZ_DONE: begin
          // Result leaves EX this cycle; ex_mdu_op is still the same
          // instruction, so it must not relaunch.
          state_n = HZ_IDLE;
          cnt_n   = '0;
        end
        default: begin
          state_n = HZ_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk           (clk),
    .rst_n         (rst_n),
    .inc_ld        (ld_bubble),
    .inc_mdu       (mdu_stall_cyc),
    .inc_flush     (if_id_flush | id_ex_flush | ex_mem_flush),
    .perf_ld_stall (perf_ld_stall),
    .perf_mdu_stall(perf_mdu_stall),
    .perf_flush    (perf_flush)
  );
`else
  logic unused_perf;
  assign unused_perf = ld_bubble ^ mdu_stall_cyc;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] rs1, rs2, rs3, ID_EX_rd;
  logic       use_r1, use_r2, use_r3, ID_EX_rw;
  logic [1:0] ID_EX_WBSel;
  logic       ex_redirect, ex_mdu_op, mem_trap, mdu_done;

  logic mdu_start, mdu_abort, pc_stall, if_id_stall, id_ex_stall;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mdu_timeout_err;
  hz_state_t dbg_state;

  logic to_start, to_abort, to_pc_stall, to_if_id_stall, to_id_ex_stall;
  logic to_if_id_flush, to_id_ex_flush, to_ex_mem_flush, to_err;
  hz_state_t to_state;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_ld_stall, perf_mdu_stall, perf_flush;
  logic [31:0] to_perf_ld, to_perf_mdu, to_perf_flush;
`endif

  // {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush, ex_mem_flush, mdu_start, mdu_abort}
  logic [7:0] ctl, to_ctl;
  assign ctl    = {pc_stall, if_id_stall, id_ex_stall, if_id_flush, id_ex_flush,
                   ex_mem_flush, mdu_start, mdu_abort};
  assign to_ctl = {to_pc_stall, to_if_id_stall, to_id_ex_stall, to_if_id_flush,
                   to_id_ex_flush, to_ex_mem_flush, to_start, to_abort};

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rs3(rs3),
    .use_r1(use_r1), .use_r2(use_r2), .use_r3(use_r3),
    .ID_EX_rd(ID_EX_rd), .ID_EX_rw(ID_EX_rw), .ID_EX_WBSel(ID_EX_WBSel),
    .ex_redirect(ex_redirect), .ex_mdu_op(ex_mdu_op), .mem_trap(mem_trap),
    .mdu_done(mdu_done), .mdu_start(mdu_start), .mdu_abort(mdu_abort),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .mdu_timeout_err(mdu_timeout_err), .dbg_state(dbg_state)
`ifdef HAZARD_PERF_EN
    , .perf_ld_stall(perf_ld_stall), .perf_mdu_stall(perf_mdu_stall), .perf_flush(perf_flush)
`endif
  );

  hazard_ctrl #(.MDU_TIMEOUT(8)) dut_to (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .rs3(rs3),
    .use_r1(use_r1), .use_r2(use_r2), .use_r3(use_r3),
    .ID_EX_rd(ID_EX_rd), .ID_EX_rw(ID_EX_rw), .ID_EX_WBSel(ID_EX_WBSel),
    .ex_redirect(ex_redirect), .ex_mdu_op(ex_mdu_op), .mem_trap(mem_trap),
    .mdu_done(mdu_done), .mdu_start(to_start), .mdu_abort(to_abort),
    .pc_stall(to_pc_stall), .if_id_stall(to_if_id_stall), .id_ex_stall(to_id_ex_stall),
    .if_id_flush(to_if_id_flush), .id_ex_flush(to_id_ex_flush), .ex_mem_flush(to_ex_mem_flush),
    .mdu_timeout_err(to_err), .dbg_state(to_state)
`ifdef HAZARD_PERF_EN
    , .perf_ld_stall(to_perf_ld), .perf_mdu_stall(to_perf_mdu), .perf_flush(to_perf_flush)
`endif
  );

  int checks = 0;
  int errors = 0;

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    rs1 = '0; rs2 = '0; rs3 = '0; ID_EX_rd = '0;
    use_r1 = 0; use_r2 = 0; use_r3 = 0; ID_EX_rw = 0; ID_EX_WBSel = 2'b00;
    ex_redirect = 0; ex_mdu_op = 0; mem_trap = 0; mdu_done = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_load(input logic [4:0] rd);
    ID_EX_WBSel = 2'b01; ID_EX_rw = 1'b1; ID_EX_rd = rd;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctl !== 8'h00) begin errors++; $display("FAIL reset_ctl got %h exp 00", ctl); end
    checks++;
    if (dbg_state !== HZ_IDLE) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    checks++;
    if (mdu_timeout_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", mdu_timeout_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_inputs(); set_load(5'd5); rs1 = 5'd5; use_r1 = 1; #1;
    checks++;
    if (ctl !== 8'hC8) begin errors++; $display("FAIL ld_use_rs1 got %h exp c8", ctl); end
    // bubble now in EX: normal flow
    @(negedge clk);
    ID_EX_WBSel = 2'b00; ID_EX_rw = 0; ID_EX_rd = '0; #1;
    checks++;
    if (ctl !== 8'h00) begin errors++; $display("FAIL ld_use_after got %h exp 00", ctl); end
    @(negedge clk);
    clear_inputs(); set_load(5'd9); rs2 = 5'd9; use_r2 = 1; rs1 = 5'd3; use_r1 = 1; #1;
    checks++;
    if (ctl !== 8'hC8) begin errors++; $display("FAIL ld_use_rs2 got %h exp c8", ctl); end
    @(negedge clk);
    clear_inputs(); set_load(5'd7); rs3 = 5'd7; use_r3 = 1; #1;
    checks++;
    if (ctl !== 8'h00) begin errors++; $display("FAIL ld_use_rs3 got %h exp 00", ctl); end
  endtask

  task automatic test_no_stall();
    @(negedge clk);
    clear_inputs(); set_load(5'd0); rs1 = 5'd0; use_r1 = 1; #1;
    checks++;
    if (ctl !== 8'h00) begin errors++; $display("FAIL nostall_x0 got %h exp 00", ctl); end
    @(negedge clk);
    clear_inputs(); set_load(5'd5); rs2 = 5'd5; use_r2 = 0; #1;
    checks++;
    if (ctl !== 8'h00) begin errors++; $display("FAIL nostall_use0 got %h exp 00", ctl); end
    @(negedge clk);
    clear_inputs(); ID_EX_WBSel = 2'b10; ID_EX_rw = 1; ID_EX_rd = 5'd5; rs1 = 5'd5; use_r1 = 1; #1;
    checks++;
    if (ctl !== 8'h00) begin errors++; $display("FAIL nostall_notload got %h exp 00", ctl); end
    @(negedge clk);
    clear_inputs(); ID_EX_WBSel = 2'b01; ID_EX_rw = 0; ID_EX_rd = 5'd5; rs1 = 5'd5; use_r1 = 1; #1;
    checks++;
    if (ctl !== 8'h00) begin errors++; $display("FAIL nostall_norw got %h exp 00", ctl); end
  endtask

  task automatic test_mdu_done();
    int stalls = 0;
    int starts = 0;
    @(negedge clk);
    clear_inputs(); ex_mdu_op = 1; #1;
    checks++;
    if (ctl !== 8'hE6) begin errors++; $display("FAIL mdu_launch got %h exp e6", ctl); end
    if (pc_stall) stalls++;
    if (mdu_start) starts++;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      mdu_done = (c == 10); #1;
      checks++;
      if (ctl !== 8'hE4) begin errors++; $display("FAIL mdu_busy c%0d got %h exp e4", c, ctl); end
      if (pc_stall) stalls++;
      if (mdu_start) starts++;
    end
    @(negedge clk);
    mdu_done = 0; #1;   // ex_mdu_op still high: same instruction leaving EX
    checks++;
    if (dbg_state !== HZ_DONE) begin errors++; $display("FAIL mdu_done_state got %0d exp 2", dbg_state); end
    checks++;
    if (ctl !== 8'h00) begin errors++; $display("FAIL mdu_done_ctl got %h exp 00", ctl); end
    if (mdu_start) starts++;
    @(negedge clk);
    ex_mdu_op = 0; #1;
    checks++;
    if (dbg_state !== HZ_IDLE || ctl !== 8'h00) begin
      errors++; $display("FAIL mdu_after got state %0d ctl %h exp 0 00", dbg_state, ctl);
    end
    checks++;
    if (stalls !== 11) begin errors++; $display("FAIL mdu_stall_cycles got %0d exp 11", stalls); end
    checks++;
    if (starts !== 1) begin errors++; $display("FAIL mdu_start_pulses got %0d exp 1", starts); end
  endtask

  task automatic test_timeout();
    do_reset();
    @(negedge clk);
    ex_mdu_op = 1; #1;
    checks++;
    if (to_ctl !== 8'hE6) begin errors++; $display("FAIL to_launch got %h exp e6", to_ctl); end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (to_ctl !== ((c == 8) ? 8'hE5 : 8'hE4)) begin
        errors++; $display("FAIL to_busy c%0d got %h exp %h", c, to_ctl, (c == 8) ? 8'hE5 : 8'hE4);
      end
    end
    checks++;
    if (ctl !== 8'hE4) begin errors++; $display("FAIL to_long_no_abort got %h exp e4", ctl); end
    @(negedge clk);
    ex_mdu_op = 0; #1;
    checks++;
    if (to_err !== 1'b1 || to_state !== HZ_IDLE || to_ctl !== 8'h00) begin
      errors++; $display("FAIL to_after got err %b state %0d ctl %h exp 1 0 00", to_err, to_state, to_ctl);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (to_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", to_err); end
    // main instance still busy: async reset must drop it to IDLE without abort
    checks++;
    if (dbg_state !== HZ_BUSY) begin errors++; $display("FAIL to_long_busy got %0d exp 1", dbg_state); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dbg_state !== HZ_IDLE || ctl !== 8'h00) begin
      errors++; $display("FAIL async_rst got state %0d ctl %h exp 0 00", dbg_state, ctl);
    end
    checks++;
    if (to_err !== 1'b0) begin errors++; $display("FAIL to_err_clear got %b exp 0", to_err); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_trap_busy();
    @(negedge clk);
    clear_inputs(); ex_mdu_op = 1;
    repeat (4) @(negedge clk);
    mem_trap = 1; mdu_done = 1; #1;
    checks++;
    if (ctl !== 8'h1D) begin errors++; $display("FAIL trap_busy got %h exp 1d", ctl); end
    @(negedge clk);
    clear_inputs(); #1;
    checks++;
    if (dbg_state !== HZ_IDLE || ctl !== 8'h00) begin
      errors++; $display("FAIL trap_after got state %0d ctl %h exp 0 00", dbg_state, ctl);
    end
    @(negedge clk);
    mem_trap = 1; set_load(5'd4); rs1 = 5'd4; use_r1 = 1; #1;
    checks++;
    if (ctl !== 8'h1C) begin errors++; $display("FAIL trap_idle got %h exp 1c", ctl); end
  endtask

  task automatic test_redirect_load_use();
`ifdef HAZARD_PERF_EN
    logic [31:0] flush_before;
`endif
    @(negedge clk);
    clear_inputs(); #1;
`ifdef HAZARD_PERF_EN
    flush_before = perf_flush;
`endif
    @(negedge clk);
    set_load(5'd12); rs1 = 5'd12; use_r1 = 1; ex_redirect = 1; #1;
    checks++;
    if (ctl !== 8'h18) begin errors++; $display("FAIL redirect_ld got %h exp 18", ctl); end
    @(negedge clk);
    clear_inputs(); #1;
    checks++;
    if (ctl !== 8'h00) begin errors++; $display("FAIL redirect_after got %h exp 00", ctl); end
`ifdef HAZARD_PERF_EN
    checks++;
    if (perf_flush !== flush_before + 32'd1) begin
      errors++; $display("FAIL perf_flush got %0d exp %0d", perf_flush, flush_before + 32'd1);
    end
`endif
  endtask

  task automatic test_back_to_back();
    // two consecutive load-use bubbles from different loads
    @(negedge clk);
    clear_inputs(); set_load(5'd1); rs1 = 5'd1; use_r1 = 1; #1;
    checks++;
    if (ctl !== 8'hC8) begin errors++; $display("FAIL b2b_first got %h exp c8", ctl); end
    @(negedge clk);
    set_load(5'd2); rs1 = 5'd1; rs2 = 5'd2; use_r2 = 1; #1;
    checks++;
    if (ctl !== 8'hC8) begin errors++; $display("FAIL b2b_second got %h exp c8", ctl); end
    @(negedge clk);
    clear_inputs();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_no_stall();
    test_mdu_done();
    test_timeout();
    test_trap_busy();
    test_redirect_load_use();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
